// File: rtl/spike_encoder_pkg.sv
// Shared types and default sizing for the rate-coding spike encoder.
package spike_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_N_CH    = 8;
  localparam int DEF_W       = 8;
  localparam int DEF_WIN_LEN = 256;

  // Window counter width; a one-cycle window still needs one bit.
  function automatic int cnt_width(input int win_len);
    return (win_len > 1) ? $clog2(win_len) : 1;
  endfunction

endpackage

// File: rtl/spike_encoder_if.sv
// Control, intensity-load and spike-output bundle between controller and encoder.
interface spike_encoder_if #(
  parameter int N_CH = 8,
  parameter int W    = 8
) ();
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic            load_valid;
  logic [CH_W-1:0] load_ch;
  logic [W-1:0]    load_value;
  logic            load_ready;
  logic            start;
  logic            abort;
  logic            learn_en;
  logic            learn;
  logic [N_CH-1:0] spikes;
  logic            busy;
  logic            done;

  modport master (
    output load_valid, load_ch, load_value, start, abort, learn_en,
    input  load_ready, learn, spikes, busy, done
  );

  modport slave (
    input  load_valid, load_ch, load_value, start, abort, learn_en,
    output load_ready, learn, spikes, busy, done
  );
endinterface

// File: rtl/spike_encoder_rate_channel.sv
// One rate-coded channel: intensity register plus phase accumulator whose carry
// is the registered spike, so intensity k yields k spikes per 2^W steps.
module rate_channel #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         clear_i,
  input  logic         step_i,
  output logic         spike_o
);
  logic [W-1:0] int_q;
  logic [W-1:0] acc_q;
  logic         spike_q;
  logic [W:0]   sum_d;

  assign sum_d   = {1'b0, acc_q} + {1'b0, int_q};
  assign spike_o = spike_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      int_q   <= '0;
      acc_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      if (wr_en_i) begin
        int_q <= wr_data_i;
      end
      if (clear_i) begin
        acc_q <= '0;
      end else if (step_i) begin
        acc_q <= sum_d[W-1:0];
      end
      // Any non-stepping cycle (IDLE, DONE, abort) drops the spike line.
      spike_q <= step_i & sum_d[W];
    end
  end
endmodule

// File: rtl/spike_encoder.sv
// Window FSM and counter driving N_CH rate channels; spikes lag the RUN cycle
// that produced them by one cycle, so the last one lands in the DONE cycle.
module spike_encoder
  import spike_encoder_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int W       = DEF_W,
  parameter int WIN_LEN = DEF_WIN_LEN
) (
  input  logic           clk_i,
  input  logic           reset_i,
  spike_encoder_if.slave enc_if
);
  localparam int CNT_W = cnt_width(WIN_LEN);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            last_cyc;
  logic            load_acc;
  logic            clear;
  logic            step;
  logic            ready_o, busy_o, done_o, learn_o;
  logic [N_CH-1:0] wr_en;
  logic [N_CH-1:0] spikes_o;

  assign last_cyc = (cnt_q == CNT_W'(WIN_LEN - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Abort is checked before the window end so it always wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (enc_if.start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (enc_if.abort) begin
          state_d = IDLE;
        end else if (last_cyc) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o  = (state_q == IDLE);
    busy_o   = (state_q == RUN) || (state_q == DONE);
    done_o   = (state_q == DONE);
    learn_o  = enc_if.learn_en && (state_q == RUN);
    load_acc = enc_if.load_valid && ready_o;
    clear    = ((state_q == IDLE) && enc_if.start) || ((state_q == RUN) && enc_if.abort);
    step     = (state_q == RUN) && !enc_if.abort;
    for (int i = 0; i < N_CH; i++) begin
      wr_en[i] = load_acc && (int'(enc_if.load_ch) == i);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    rate_channel #(.W(W)) u_ch (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .wr_en_i   (wr_en[g]),
      .wr_data_i (enc_if.load_value),
      .clear_i   (clear),
      .step_i    (step),
      .spike_o   (spikes_o[g])
    );
  end

  assign enc_if.load_ready = ready_o;
  assign enc_if.busy       = busy_o;
  assign enc_if.done       = done_o;
  assign enc_if.learn      = learn_o;
  assign enc_if.spikes     = spikes_o;
endmodule

// File: tb/tb_spike_encoder.sv
// Bench for spike_encoder: window results go through a scoreboard checked on each done pulse.
module tb_spike_encoder;
  localparam int N_CH = 8;
  localparam int WL   = 256;

  logic clk;
  logic rst;

  spike_encoder_if #(.N_CH(N_CH), .W(8)) a_if ();
  spike_encoder_if #(.N_CH(N_CH), .W(8)) b_if ();

  spike_encoder #(.N_CH(N_CH), .W(8), .WIN_LEN(WL)) u_dut (
    .clk_i(clk), .reset_i(rst), .enc_if(a_if)
  );
  spike_encoder #(.N_CH(N_CH), .W(8), .WIN_LEN(1)) u_dut_short (
    .clk_i(clk), .reset_i(rst), .enc_if(b_if)
  );

  typedef struct packed {
    logic [N_CH-1:0][8:0] cnt;
    logic [9:0]           len;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   mdl_int[N_CH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int ch, input int val);
    a_if.load_valid = 1'b1;
    a_if.load_ch    = 3'(ch);
    a_if.load_value = 8'(val);
    if (a_if.load_ready && ch < N_CH) mdl_int[ch] = val;
    tick();
    a_if.load_valid = 1'b0;
  endtask

  task automatic push_exp();
    exp_t e;
    for (int i = 0; i < N_CH; i++) e.cnt[i] = 9'((mdl_int[i] * WL) >> 8);
    e.len = 10'(WL + 1);
    exp_q.push_back(e);
  endtask

  task automatic start_win(input bit expect_done);
    if (expect_done) push_exp();
    a_if.start = 1'b1;
    tick();
    a_if.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int budget;
    budget = 1000;
    while (a_if.busy && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check({name, "_timeout"}, 1, 0);
  endtask

  // Monitor: counts spikes per window and scores each done pulse.
  initial begin
    int   ccnt[N_CH];
    int   blen;
    logic busy_prev;
    exp_t e;
    blen      = 0;
    busy_prev = 1'b0;
    for (int i = 0; i < N_CH; i++) ccnt[i] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_prev = 1'b0;
      end else begin
        if (a_if.busy && !busy_prev) begin
          blen = 0;
          for (int i = 0; i < N_CH; i++) ccnt[i] = 0;
        end
        if (a_if.busy) begin
          blen++;
          for (int i = 0; i < N_CH; i++) ccnt[i] += int'(a_if.spikes[i]);
        end
        if (a_if.done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < N_CH; i++)
              check($sformatf("ch%0d_count", i), ccnt[i], int'(e.cnt[i]));
            check("window_len", blen, int'(e.len));
          end
        end
        busy_prev = a_if.busy;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_learn;
    int learn_bad;
    int done_seen;
    int budget;

    rst = 1'b1;
    a_if.load_valid = 1'b0; a_if.load_ch = '0; a_if.load_value = '0;
    a_if.start = 1'b0; a_if.abort = 1'b0; a_if.learn_en = 1'b0;
    b_if.load_valid = 1'b0; b_if.load_ch = '0; b_if.load_value = '0;
    b_if.start = 1'b0; b_if.abort = 1'b0; b_if.learn_en = 1'b0;
    for (int i = 0; i < N_CH; i++) mdl_int[i] = 0;
    repeat (3) tick();
    check("rst_spikes", int'(a_if.spikes), 0);
    check("rst_busy", int'(a_if.busy), 0);
    check("rst_done", int'(a_if.done), 0);
    check("rst_load_ready", int'(a_if.load_ready), 1);
    rst = 1'b0;
    tick();

    // Reset mid-window with a spiking channel.
    load(0, 255);
    start_win(1'b0);
    repeat (20) tick();
    check("pre_reset_spike", int'(a_if.spikes[0]), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_spikes", int'(a_if.spikes), 0);
    check("async_rst_busy", int'(a_if.busy), 0);
    check("async_rst_done", int'(a_if.done), 0);
    check("async_rst_ready", int'(a_if.load_ready), 1);
    for (int i = 0; i < N_CH; i++) mdl_int[i] = 0;
    tick();
    rst = 1'b0;
    tick();
    start_win(1'b1);
    wait_idle("zero_window");

    // Mixed intensities.
    load(0, 128); load(1, 0); load(2, 255); load(3, 1);
    start_win(1'b1);
    wait_idle("mixed_window");

    // Abort at RUN cycle 100, then restart from a cleared accumulator.
    load(0, 64);
    start_win(1'b0);
    repeat (99) tick();
    a_if.abort = 1'b1;
    tick();
    a_if.abort = 1'b0;
    check("abort_busy", int'(a_if.busy), 0);
    check("abort_spikes", int'(a_if.spikes), 0);
    check("abort_ready", int'(a_if.load_ready), 1);
    done_seen = 0;
    for (int k = 0; k < 5; k++) begin
      done_seen += int'(a_if.done);
      tick();
    end
    check("abort_no_done", done_seen, 0);
    start_win(1'b1);
    wait_idle("after_abort");

    // Load in the same cycle as start; load during RUN is dropped.
    a_if.load_valid = 1'b1; a_if.load_ch = 3'd5; a_if.load_value = 8'd200;
    mdl_int[5] = 200;
    start_win(1'b1);
    a_if.load_valid = 1'b0;
    repeat (10) tick();
    check("run_load_ready", int'(a_if.load_ready), 0);
    load(5, 10);
    wait_idle("collide_window");
    start_win(1'b1);
    wait_idle("dropped_load_window");

    // Learn gating, with a stray start in the middle of RUN.
    a_if.learn_en = 1'b1;
    tick();
    check("learn_idle", int'(a_if.learn), 0);
    start_win(1'b1);
    n_learn = 0; learn_bad = 0; budget = 400;
    while (a_if.busy && budget > 0) begin
      if (a_if.done) learn_bad += int'(a_if.learn);
      else n_learn += int'(a_if.learn);
      a_if.start = (budget == 350);
      tick();
      budget--;
    end
    a_if.start = 1'b0;
    check("learn_run_cycles", n_learn, WL);
    check("learn_in_done", learn_bad, 0);
    check("learn_after_idle", int'(a_if.learn), 0);
    a_if.learn_en = 1'b0;

    // One-cycle window: ch0=255 produces no carry on its only step.
    b_if.load_valid = 1'b1; b_if.load_ch = 3'd0; b_if.load_value = 8'd255;
    tick();
    b_if.load_valid = 1'b0;
    b_if.start = 1'b1;
    tick();
    b_if.start = 1'b0;
    check("short_run_busy", int'(b_if.busy), 1);
    check("short_run_done", int'(b_if.done), 0);
    tick();
    check("short_done", int'(b_if.done), 1);
    check("short_done_spikes", int'(b_if.spikes), 0);
    tick();
    check("short_idle_busy", int'(b_if.busy), 0);
    check("short_idle_spikes", int'(b_if.spikes), 0);

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
